// File: rtl/contador_modulo_ajustable_pkg.sv
// ---------------------------------------------------------------------------
// contador_modulo_ajustable_pkg
// Shared definitions for the adjustable modulo counter:
//   estado_t : auto-repeat FSM states (idle, waiting for hold, repeating)
//   dir_t    : step direction codes (up / down)
// ---------------------------------------------------------------------------
package contador_modulo_ajustable_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ESPERA = 2'd1,
    ST_REPITE = 2'd2
  } estado_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage : contador_modulo_ajustable_pkg

// File: rtl/autorrepeticion_boton.sv
// ---------------------------------------------------------------------------
// autorrepeticion_boton
// Turns two debounced button levels into single-cycle step pulses: one step
// on a fresh press, then after HOLD_CYCLES of continuous holding one step
// every REPEAT_CYCLES until the button is released or the other one joins.
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   boton_aumenta    in   "up" button level (synchronised, debounced)
//   boton_disminuye  in   "down" button level (synchronised, debounced)
//   paso             out  1-cycle step request
//   paso_dir         out  direction of the step request
// ---------------------------------------------------------------------------
module autorrepeticion_boton
  import contador_modulo_ajustable_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TIMER_WIDTH   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_aumenta,
  input  logic boton_disminuye,
  output logic paso,
  output dir_t paso_dir
);

  localparam logic [TIMER_WIDTH-1:0] HOLD_LAST   = TIMER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] REPEAT_LAST = TIMER_WIDTH'(REPEAT_CYCLES - 1);

  estado_t                estado, estado_next;
  dir_t                   dir_q, dir_next;
  logic [TIMER_WIDTH-1:0] timer, timer_next;
  logic                   aumenta_prev, disminuye_prev;
  // Blocks new presses until both buttons have been seen low. Armed by a
  // two-button press and by reset while a button is held, so neither case
  // can produce a step without a clean release first.
  logic                   bloqueo, bloqueo_next;
  logic                   boton_latched, boton_otro;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= ST_IDLE;
      dir_q          <= DIR_UP;
      timer          <= '0;
      aumenta_prev   <= 1'b0;
      disminuye_prev <= 1'b0;
      bloqueo        <= boton_aumenta | boton_disminuye;
    end else begin
      estado         <= estado_next;
      dir_q          <= dir_next;
      timer          <= timer_next;
      aumenta_prev   <= boton_aumenta;
      disminuye_prev <= boton_disminuye;
      bloqueo        <= bloqueo_next;
    end
  end

  assign boton_latched = (dir_q == DIR_UP) ? boton_aumenta   : boton_disminuye;
  assign boton_otro    = (dir_q == DIR_UP) ? boton_disminuye : boton_aumenta;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgets one would otherwise infer a latch.
    estado_next  = estado;
    dir_next     = dir_q;
    timer_next   = timer;
    bloqueo_next = bloqueo;
    paso         = 1'b0;

    unique case (estado)
      ST_IDLE: begin
        if (boton_aumenta && boton_disminuye) begin
          bloqueo_next = 1'b1;
        end else if (!bloqueo && boton_aumenta && !aumenta_prev) begin
          paso        = 1'b1;
          dir_next    = DIR_UP;
          timer_next  = '0;
          estado_next = ST_ESPERA;
        end else if (!bloqueo && boton_disminuye && !disminuye_prev) begin
          paso        = 1'b1;
          dir_next    = DIR_DOWN;
          timer_next  = '0;
          estado_next = ST_ESPERA;
        end
      end

      ST_ESPERA: begin
        if (!boton_latched || boton_otro) begin
          timer_next  = '0;
          estado_next = ST_IDLE;
        end else if (timer == HOLD_LAST) begin
          paso        = 1'b1;
          timer_next  = '0;
          estado_next = ST_REPITE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_REPITE: begin
        if (!boton_latched || boton_otro) begin
          timer_next  = '0;
          estado_next = ST_IDLE;
        end else if (timer == REPEAT_LAST) begin
          paso       = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: begin
        timer_next  = '0;
        estado_next = ST_IDLE;
      end
    endcase

    if (!boton_aumenta && !boton_disminuye) bloqueo_next = 1'b0;
  end

  // In IDLE the step direction is the one being latched this cycle.
  assign paso_dir = dir_next;

endmodule : autorrepeticion_boton

// File: rtl/contador_modulo_ajustable.sv
// ---------------------------------------------------------------------------
// contador_modulo_ajustable
// Modulo-MODULO up/down counter for the clock/timer datapath. Counts on
// tick_in, can be stepped by two buttons (with auto-repeat) and loaded in
// parallel. Wraps driven by tick_in produce carry/borrow pulses so stages
// can be cascaded.
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   tick_in          in   count enable (timebase or lower-stage carry/borrow)
//   direccion        in   tick direction: 0 = up, 1 = down
//   boton_aumenta    in   "up" button level
//   boton_disminuye  in   "down" button level
//   load             in   synchronous load strobe
//   load_value       in   value to load (saturated to MODULO-1)
//   count            out  current count (registered)
//   carry_out        out  1-cycle pulse on tick wrap MODULO-1 -> 0
//   borrow_out       out  1-cycle pulse on tick wrap 0 -> MODULO-1
// Priority per cycle: reset > load > button step > tick.
// ---------------------------------------------------------------------------
module contador_modulo_ajustable
  import contador_modulo_ajustable_pkg::*;
#(
  parameter int MODULO        = 60,
  parameter int WIDTH         = 6,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TIMER_WIDTH   = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             direccion,
  input  logic             boton_aumenta,
  input  logic             boton_disminuye,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MODULO_W  = (WIDTH + 1)'(MODULO);

  logic paso;
  dir_t paso_dir;

  autorrepeticion_boton #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .TIMER_WIDTH  (TIMER_WIDTH)
  ) u_autorrepeticion (
    .clk            (clk),
    .reset          (reset),
    .boton_aumenta  (boton_aumenta),
    .boton_disminuye(boton_disminuye),
    .paso           (paso),
    .paso_dir       (paso_dir)
  );

  // Wrap by explicit comparison; the counter range is generally not a
  // power of two, so natural WIDTH overflow cannot be relied on.
  function automatic logic [WIDTH-1:0] paso_arriba(input logic [WIDTH-1:0] v);
    return (v == MAX_COUNT) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] paso_abajo(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX_COUNT : v - 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
    end else begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      if (load) begin
        count <= ({1'b0, load_value} >= MODULO_W) ? MAX_COUNT : load_value;
      end else if (paso) begin
        count <= (paso_dir == DIR_DOWN) ? paso_abajo(count) : paso_arriba(count);
      end else if (tick_in) begin
        if (direccion) begin
          count      <= paso_abajo(count);
          borrow_out <= (count == '0);
        end else begin
          count     <= paso_arriba(count);
          carry_out <= (count == MAX_COUNT);
        end
      end
    end
  end

endmodule : contador_modulo_ajustable

// File: tb/tb_contador_modulo_ajustable.sv
// ---------------------------------------------------------------------------
// tb_contador_modulo_ajustable
// Directed scenarios followed by randomized stimulus, all compared against a
// behavioural model that computes the count with modular arithmetic and the
// auto-repeat schedule from the number of cycles a button has been held.
// ---------------------------------------------------------------------------
module tb_contador_modulo_ajustable;

  localparam int MOD  = 60;
  localparam int W    = 6;
  localparam int HOLD = 4;
  localparam int REP  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick_in;
  logic         direccion;
  logic         boton_aumenta;
  logic         boton_disminuye;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         carry_out;
  logic         borrow_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int m_count   = 0;
  int m_active  = 0;  // 0 = no button held, 1 = up held, 2 = down held
  int m_k       = 0;  // cycles since the held button was pressed
  bit m_blocked = 0;
  bit m_pa      = 0;
  bit m_pd      = 0;
  bit m_carry   = 0;
  bit m_borrow  = 0;

  contador_modulo_ajustable #(
    .MODULO       (MOD),
    .WIDTH        (W),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .TIMER_WIDTH  (26)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_in        (tick_in),
    .direccion      (direccion),
    .boton_aumenta  (boton_aumenta),
    .boton_disminuye(boton_disminuye),
    .load           (load),
    .load_value     (load_value),
    .count          (count),
    .carry_out      (carry_out),
    .borrow_out     (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock of the reference model, given the inputs sampled on that edge.
  task automatic model_step(input bit r, t, d, a, dn, ld, input int lv);
    bit step;
    bit down;
    bit held;
    bit other;
    step     = 0;
    down     = 0;
    m_carry  = 0;
    m_borrow = 0;
    if (r) begin
      m_count   = 0;
      m_active  = 0;
      m_k       = 0;
      m_pa      = 0;
      m_pd      = 0;
      m_blocked = a | dn;
      return;
    end
    if (m_active != 0) begin
      held  = (m_active == 1) ? a : dn;
      other = (m_active == 1) ? dn : a;
      if (!held || other) begin
        m_active = 0;
      end else begin
        m_k++;
        if (m_k == HOLD || (m_k > HOLD && (m_k - HOLD) % REP == 0)) begin
          step = 1;
          down = (m_active == 2);
        end
      end
    end else if (a && dn) begin
      m_blocked = 1;
    end else if (!m_blocked && a && !m_pa) begin
      step = 1; down = 0; m_active = 1; m_k = 0;
    end else if (!m_blocked && dn && !m_pd) begin
      step = 1; down = 1; m_active = 2; m_k = 0;
    end
    if (!a && !dn) m_blocked = 0;
    m_pa = a;
    m_pd = dn;

    if (ld) begin
      m_count = (lv >= MOD) ? MOD - 1 : lv;
    end else if (step) begin
      m_count = down ? (m_count + MOD - 1) % MOD : (m_count + 1) % MOD;
    end else if (t) begin
      if (!d) begin
        m_carry = (m_count == MOD - 1);
        m_count = (m_count + 1) % MOD;
      end else begin
        m_borrow = (m_count == 0);
        m_count  = (m_count + MOD - 1) % MOD;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare.
  task automatic apply(input bit r, t, d, a, dn, ld, input int lv);
    reset           = r;
    tick_in         = t;
    direccion       = d;
    boton_aumenta   = a;
    boton_disminuye = dn;
    load            = ld;
    load_value      = W'(lv);
    @(posedge clk);
    model_step(r, t, d, a, dn, ld, lv & 63);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("carry_out", 32'(carry_out), 32'(m_carry));
    check("borrow_out", 32'(borrow_out), 32'(m_borrow));
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_to(input int v);
    apply(0, 0, 0, 0, 0, 1, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, dn;
    reset = 1; tick_in = 0; direccion = 0; boton_aumenta = 0;
    boton_disminuye = 0; load = 0; load_value = '0;

    // 1: reset with every input high, then buttons still held afterwards.
    apply(1, 1, 1, 1, 1, 1, 63);
    apply(1, 1, 1, 1, 1, 1, 63);
    check("t1_reset_count", 32'(count), 0);
    check("t1_reset_carry", 32'(carry_out), 0);
    check("t1_reset_borrow", 32'(borrow_out), 0);
    for (int i = 0; i < 6; i++) apply(0, 0, 0, 1, 0, 0, 0);
    check("t1_held_after_reset", 32'(count), 0);
    idle();
    apply(0, 0, 0, 1, 0, 0, 0);
    check("t1_repress", 32'(count), 1);
    idle();

    // 2: tick wraps with carry and borrow.
    load_to(59);
    apply(0, 1, 0, 0, 0, 0, 0);
    check("t2_wrap_up_count", 32'(count), 0);
    check("t2_carry", 32'(carry_out), 1);
    idle();
    check("t2_carry_one_cycle", 32'(carry_out), 0);
    load_to(0);
    apply(0, 1, 1, 0, 0, 0, 0);
    check("t2_wrap_down_count", 32'(count), 59);
    check("t2_borrow", 32'(borrow_out), 1);
    idle();
    check("t2_borrow_one_cycle", 32'(borrow_out), 0);

    // 3: hold up button for 12 cycles -> steps at 0, 4, 6, 8, 10.
    load_to(10);
    for (int i = 0; i < 12; i++) apply(0, 0, 0, 1, 0, 0, 0);
    check("t3_autorepeat", 32'(count), 15);
    idle();
    apply(0, 0, 0, 1, 0, 0, 0);
    check("t3_idle_after_release", 32'(count), 16);
    idle();

    // 4: manual down step wraps without borrow; tick in same cycle dropped.
    load_to(0);
    apply(0, 0, 0, 0, 1, 0, 0);
    check("t4_down_wrap", 32'(count), 59);
    check("t4_no_borrow", 32'(borrow_out), 0);
    idle();
    load_to(0);
    apply(0, 1, 0, 0, 1, 0, 0);
    check("t4_tick_dropped", 32'(count), 59);
    check("t4_tick_no_carry", 32'(carry_out), 0);
    idle();

    // 5: load, saturating load, load beats a button edge.
    load_to(45);
    check("t5_load", 32'(count), 45);
    load_to(63);
    check("t5_load_sat", 32'(count), 59);
    apply(0, 0, 0, 1, 0, 1, 45);
    check("t5_load_wins", 32'(count), 45);
    idle();

    // 6: both buttons together never step until both released.
    load_to(20);
    apply(0, 0, 0, 1, 1, 0, 0);
    check("t6_both", 32'(count), 20);
    for (int i = 0; i < 6; i++) apply(0, 0, 0, 1, 0, 0, 0);
    check("t6_drop_down", 32'(count), 20);
    idle();
    apply(0, 0, 0, 1, 0, 0, 0);
    check("t6_fresh_press", 32'(count), 21);
    idle();

    // Randomized stimulus: buttons change rarely so holds and auto-repeat
    // occur often; loads and resets are occasional.
    a  = 0;
    dn = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) a  = ~a;
      if ($urandom_range(0, 7) == 0) dn = ~dn;
      apply($urandom_range(0, 199) == 0,
            $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)),
            a, dn,
            $urandom_range(0, 39) == 0,
            int'($urandom_range(0, 63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_contador_modulo_ajustable
